// File: rtl/decryptor_iterative.sv
// -----------------------------------------------------------------------------
// decryptor_iterative
//
// Iterative TEA block decryptor. One 64-bit ciphertext block is accepted with
// its 128-bit key, then one decryption round is applied per clock until ROUNDS
// rounds are done. The plaintext is held on data_out with out_valid high until
// the consumer takes it, after which the block returns to IDLE.
//
// Parameters
//   ROUNDS    number of TEA rounds per block (1..63)
//   DELTA     TEA round constant
//
// Ports
//   clk       system clock, rising-edge active
//   rst_n     asynchronous active-low reset
//   in_valid  ciphertext/key presented
//   in_ready  high in IDLE only; a block is taken on in_valid && in_ready
//   key       128-bit key; k[n] = key[32n+31:32n]
//   data_in   ciphertext; v0 = data_in[31:0], v1 = data_in[63:32]
//   out_valid high in DONE only; data_out holds the plaintext
//   out_ready consumer accepts data_out (only looked at in DONE)
//   data_out  plaintext; v0 = data_out[31:0], v1 = data_out[63:32]
//   busy      high while rounds are being computed (RUN)
// -----------------------------------------------------------------------------
module decryptor_iterative #(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [63:0]  data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  data_out,
    output logic         busy
);

    localparam int CNT_W = 6;

    // Decryption walks the key schedule backwards, so the running sum starts
    // at the value the encryptor ended with: DELTA * ROUNDS, wrapped to 32 bits.
    localparam logic [31:0]      SUM_INIT   = DELTA * ROUNDS;
    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [127:0]       key_q,   key_d;
    logic [31:0]        v0_q,    v0_d;
    logic [31:0]        v1_q,    v1_d;
    logic [31:0]        sum_q,   sum_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    // -------------------------------------------------------------------------
    // Key words and single-round datapath
    // -------------------------------------------------------------------------
    logic [31:0] k_w [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key_word
            assign k_w[gi] = key_q[32*gi +: 32];
        end
    endgenerate

    logic [31:0] v1_mix;
    logic [31:0] v1_rnd;
    logic [31:0] v0_mix;
    logic [31:0] v0_rnd;

    // v1 is undone first (it was updated last during encryption); the v0 step
    // then uses the freshly recovered v1 value, not the registered one.
    assign v1_mix = ((v0_q << 4) + k_w[2]) ^ (v0_q + sum_q) ^ ((v0_q >> 5) + k_w[3]);
    assign v1_rnd = v1_q - v1_mix;
    assign v0_mix = ((v1_rnd << 4) + k_w[0]) ^ (v1_rnd + sum_q) ^ ((v1_rnd >> 5) + k_w[1]);
    assign v0_rnd = v0_q - v0_mix;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            v0_q    <= '0;
            v1_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        v0_d      = v0_q;
        v1_d      = v1_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    key_d   = key;
                    v0_d    = data_in[31:0];
                    v1_d    = data_in[63:32];
                    sum_d   = SUM_INIT;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                busy  = 1'b1;
                v0_d  = v0_rnd;
                v1_d  = v1_rnd;
                sum_d = sum_q - DELTA;
                cnt_d = cnt_q + CNT_W'(1);
                // cnt_q counts rounds already finished, so the edge that sees
                // LAST_ROUND is the one completing the final round.
                if (cnt_q == LAST_ROUND) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                out_valid = 1'b1;
                // Going back to IDLE (not straight to a new accept) leaves one
                // bubble cycle between consuming a result and taking a block.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign data_out = {v1_q, v0_q};

endmodule

// File: doc/decryptor_iterative.md
DECRYPTOR_ITERATIVE -- requirements
Module: decryptor_iterative

Interface
REQ-001 SHALL have parameter ROUNDS, default 32, meaning the number of TEA decryption rounds per block (legal range 1..63).
REQ-002 SHALL have parameter DELTA, default 32'h9E3779B9, meaning the TEA round constant.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  data_in/key presented for decryption.
REQ-006 SHALL have port in_ready  output  1  block can accept a new ciphertext.
REQ-007 SHALL have port key  input  128  k[0]=key[31:0], k[1]=key[63:32], k[2]=key[95:64], k[3]=key[127:96].
REQ-008 SHALL have port data_in  input  64  ciphertext; v0=data_in[31:0], v1=data_in[63:32].
REQ-009 SHALL have port out_valid  output  1  data_out holds a finished plaintext.
REQ-010 SHALL have port out_ready  input  1  downstream accepts data_out.
REQ-011 SHALL have port data_out  output  64  plaintext; v0=data_out[31:0], v1=data_out[63:32].
REQ-012 SHALL have port busy  output  1  high while in RUN state.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE, out_valid=1 only in DONE, busy=1 only in RUN.
REQ-015 SHALL accept a block when in_valid&&in_ready at a rising edge: latch key, v0, v1; load sum=DELTA*ROUNDS mod 2^32 (0xC6EF3720 for defaults); clear round counter; go to RUN.
REQ-016 SHALL, in RUN, perform exactly one round per clock: v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3); then v0 -= ((v1'<<4)+k0) ^ (v1'+sum) ^ ((v1'>>5)+k1), using updated v1'; then sum -= DELTA.
REQ-017 SHALL use logical (zero-fill) shifts and all arithmetic modulo 2^32.
REQ-018 SHALL go from RUN to DONE at the edge completing round ROUNDS; out_valid visible in the cycle after that edge (ROUNDS edges after the accept edge).
REQ-019 SHALL hold data_out stable and out_valid high in DONE until out_valid&&out_ready at an edge, then go to IDLE.
REQ-020 SHALL NOT accept a new block in the same cycle the result is consumed; in_ready rises the cycle after consumption (throughput one block per ROUNDS+2 cycles minimum).
REQ-021 SHALL ignore changes on key, data_in and in_valid while in RUN or DONE.
REQ-022 SHALL ignore out_ready outside DONE.
REQ-023 SHALL drive data_out from the internal v1:v0 registers; contents outside DONE are don't-care for the consumer.

Reset
REQ-024 SHALL, on rst_n low, immediately (asynchronously) force state IDLE, out_valid=0, busy=0, data_out=0, counter=0, sum=0.
REQ-025 SHALL drive in_ready=1 while and after reset (IDLE).
REQ-026 SHALL discard any in-flight block when reset asserts during RUN or DONE; no out_valid after deassertion until a new block completes.

Verification
REQ-027 Bench SHALL cover: key=0, data_in=64'h94BAA940_41EA3A0A, in_valid pulse -> out_valid exactly 32 edges after accept, data_out=64'h0.
REQ-028 Bench SHALL cover: round trip against the team's single-round encryptor iterated 32 times with sum=DELTA*i (i=1..32), key=128'h0123456789ABCDEF_FEDCBA9876543210, plaintext 64'hDEADBEEF_CAFEBABE -> decrypted data_out=64'hDEADBEEF_CAFEBABE.
REQ-029 Bench SHALL cover: out_ready held low 10 cycles in DONE -> out_valid stays 1, data_out unchanged, in_ready stays 0; out_ready=1 -> IDLE next edge, in_ready=1 one cycle later.
REQ-030 Bench SHALL cover: key and data_in toggled randomly every cycle during RUN -> result identical to REQ-027.
REQ-031 Bench SHALL cover: rst_n pulsed low at round 15 -> out_valid=0, busy=0, in_ready=1 immediately; next block decrypts correctly.
REQ-032 Bench SHALL cover: back-to-back blocks with in_valid and out_ready held high -> accepts spaced exactly ROUNDS+2 cycles, each result correct.
